// File: rtl/prbs_checker.sv
// Receive-side checker for the x^8+x^6+x^5+x^4+1 m-sequence: self-synchronises, then flywheels.
// Optional saturating compared-bit counter is built when PRBS_CHECKER_BITCNT_EN is defined.
module prbs_checker #(
  parameter int unsigned LOCK_CNT    = 16,
  parameter int unsigned WINDOW      = 256,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_bit_i,
  input  logic             in_valid_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             err_pulse_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [ERR_W-1:0] bit_cnt_o
);

  localparam int unsigned PosW = $clog2(WINDOW);

  localparam logic [7:0]      LockCntL    = LOCK_CNT[7:0];
  localparam logic [PosW:0]   LossThreshL = (PosW + 1)'(LOSS_THRESH);
  localparam logic [PosW-1:0] PosLast     = PosW'(WINDOW - 1);

  typedef enum logic {StHunt, StLocked} state_e;

  state_e           state_q;
  logic [7:0]       hist_q;
  logic [3:0]       fill_q;
  logic [7:0]       match_q;
  logic [PosW-1:0]  win_pos_q;
  logic [PosW:0]    win_err_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic             pred;
  logic             mismatch;
  logic [7:0]       match_inc;
  logic [PosW:0]    win_err_inc;
  logic             err_hit;

  always_comb begin
    pred        = hist_q[1] ^ hist_q[2] ^ hist_q[3] ^ hist_q[7];
    mismatch    = in_bit_i ^ pred;
    match_inc   = match_q + 8'd1;
    win_err_inc = win_err_q + 1'b1;
    err_hit     = in_valid_i && (state_q == StLocked) && mismatch;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StHunt;
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_pos_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= 1'b0;

      if (clr_i) begin
        err_cnt_q <= '0;
      end else if (err_hit && !(&err_cnt_q)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end

      if (in_valid_i) begin
        unique case (state_q)
          StHunt: begin
            hist_q <= {hist_q[6:0], in_bit_i};
            if (fill_q != 4'd8) begin
              fill_q <= fill_q + 4'd1;
            end else if (!mismatch && (hist_q != 8'd0)) begin
              match_q <= match_inc;
              if (match_inc == LockCntL) begin
                state_q   <= StLocked;
                locked_q  <= 1'b1;
                win_pos_q <= '0;
                win_err_q <= '0;
              end
            end else begin
              // An all-zero history would self-predict zeros forever; never count it.
              match_q <= '0;
            end
          end
          StLocked: begin
            hist_q      <= {hist_q[6:0], pred};
            win_pos_q   <= win_pos_q + 1'b1;
            err_pulse_q <= mismatch;
            if (mismatch && (win_err_inc == LossThreshL)) begin
              state_q  <= StHunt;
              locked_q <= 1'b0;
              fill_q   <= '0;
              match_q  <= '0;
            end else if (win_pos_q == PosLast) begin
              win_err_q <= '0;
            end else if (mismatch) begin
              win_err_q <= win_err_inc;
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

`ifdef PRBS_CHECKER_BITCNT_EN
  logic [ERR_W-1:0] bit_cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bit_cnt_q <= '0;
    end else if (clr_i) begin
      bit_cnt_q <= '0;
    end else if (in_valid_i && (state_q == StLocked) && !(&bit_cnt_q)) begin
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

  assign bit_cnt_o = bit_cnt_q;
`else
  assign bit_cnt_o = '0;
`endif

  assign locked_o    = locked_q;
  assign err_pulse_o = err_pulse_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock timing, flywheel errors, loss of lock, clr and reset.
module tb_prbs_checker;

  logic        clk;
  logic        reset;
  logic        in_bit;
  logic        in_valid;
  logic        clr;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [15:0] bit_cnt;

  int          total = 0;
  int          bad   = 0;
  int          pulses;
  logic        seen_lock;
  logic [7:0]  g;
  logic        b;

  prbs_checker dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .in_bit_i   (in_bit),
    .in_valid_i (in_valid),
    .clr_i      (clr),
    .locked_o   (locked),
    .err_pulse_o(err_pulse),
    .err_cnt_o  (err_cnt),
    .bit_cnt_o  (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference generator: b(n) = b(n-2)^b(n-3)^b(n-4)^b(n-8).
  task automatic gen(output logic nb);
    nb = g[1] ^ g[2] ^ g[3] ^ g[7];
    g  = {g[6:0], nb};
  endtask

  task automatic send(input logic bi, input logic v, input logic c);
    in_bit   = bi;
    in_valid = v;
    clr      = c;
    @(posedge clk);
    #1;
    pulses += int'(err_pulse);
    if (locked) seen_lock = 1'b1;
  endtask

  initial begin
    reset    = 1'b1;
    in_bit   = 1'b0;
    in_valid = 1'b0;
    clr      = 1'b0;
    g        = 8'h01;
    pulses   = 0;
    seen_lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_pulse", 32'(err_pulse), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_bit_cnt", 32'(bit_cnt), 0);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      gen(b);
      send(b, 1'b1, 1'b0);
    end
    chk("lock_not_at_23", 32'(locked), 0);
    gen(b);
    send(b, 1'b1, 1'b0);
    chk("lock_at_24", 32'(locked), 1);

    pulses = 0;
    repeat (1000) begin
      gen(b);
      send(b, 1'b1, 1'b0);
    end
    chk("clean_pulses", 32'(pulses), 0);
    chk("clean_err_cnt", 32'(err_cnt), 0);
`ifdef PRBS_CHECKER_BITCNT_EN
    chk("clean_bit_cnt", 32'(bit_cnt), 1000);
`else
    chk("clean_bit_cnt", 32'(bit_cnt), 0);
`endif

    gen(b);
    send(~b, 1'b1, 1'b0);
    chk("single_err_pulse", 32'(err_pulse), 1);
    chk("single_err_cnt", 32'(err_cnt), 1);
    chk("single_locked", 32'(locked), 1);
    pulses = 0;
    repeat (300) begin
      gen(b);
      send(b, 1'b1, 1'b0);
    end
    chk("no_err_mult", 32'(pulses), 0);
    chk("after_single_err_cnt", 32'(err_cnt), 1);
    chk("after_single_locked", 32'(locked), 1);

    send(1'b0, 1'b0, 1'b1);
    chk("clr_idle_err_cnt", 32'(err_cnt), 0);

    for (int i = 0; i < 8; i++) begin
      gen(b);
      send(~b, 1'b1, 1'b0);
      if (i == 6) chk("lock_hold_7_errs", 32'(locked), 1);
    end
    chk("loss_locked", 32'(locked), 0);
    chk("loss_err_cnt", 32'(err_cnt), 8);
    chk("loss_err_pulse", 32'(err_pulse), 1);

    for (int i = 0; i < 23; i++) begin
      gen(b);
      send(b, 1'b1, 1'b0);
    end
    chk("relock_not_at_23", 32'(locked), 0);
    gen(b);
    send(b, 1'b1, 1'b0);
    chk("relock_at_24", 32'(locked), 1);

    send(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      gen(b);
      send(~b, 1'b1, 1'b0);
      repeat (10) begin
        gen(b);
        send(b, 1'b1, 1'b0);
      end
    end
    chk("five_err_cnt", 32'(err_cnt), 5);
    chk("five_locked", 32'(locked), 1);

    // Assert reset between edges to see the asynchronous clear.
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_locked", 32'(locked), 0);
    chk("async_rst_err_cnt", 32'(err_cnt), 0);
    chk("async_rst_bit_cnt", 32'(bit_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    seen_lock = 1'b0;
    repeat (300) send(1'b0, 1'b1, 1'b0);
    chk("zeros_never_lock", 32'(seen_lock), 0);
    chk("zeros_err_cnt", 32'(err_cnt), 0);

    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      gen(b);
      send(b, 1'b1, 1'b0);
      send(1'($urandom), 1'b0, 1'b0);
      if (i == 22) chk("alt_not_locked_46", 32'(locked), 0);
    end
    chk("alt_locked_48", 32'(locked), 1);
    chk("alt_pulses", 32'(pulses), 0);

    send(1'b1, 1'b0, 1'b0);
    chk("invalid_no_pulse", 32'(err_pulse), 0);

    gen(b);
    send(~b, 1'b1, 1'b1);
    chk("clr_err_pulse", 32'(err_pulse), 1);
    chk("clr_err_cnt", 32'(err_cnt), 0);
    chk("clr_keeps_lock", 32'(locked), 1);
    chk("clr_bit_cnt", 32'(bit_cnt), 0);
    gen(b);
    send(~b, 1'b1, 1'b0);
    chk("post_clr_err_cnt", 32'(err_cnt), 1);
`ifdef PRBS_CHECKER_BITCNT_EN
    chk("post_clr_bit_cnt", 32'(bit_cnt), 1);
`else
    chk("post_clr_bit_cnt", 32'(bit_cnt), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
